// File: rtl/kernel_window_loader.sv
// rtl/kernel_window_loader.sv - fetches a 3x3 pixel window from data memory and publishes it atomically
module kernel_window_loader #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_valid,
  output logic [23:0]       cache [0:2],
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t            state;
  logic [1:0]        r;
  logic [1:0]        c;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] stride_q;
  logic [23:0]       shadow [0:2];
  logic [23:0]       row_word;
  logic              last_byte;
  logic [ADDR_W-1:0] next_row_base;

  // Current shadow row with the incoming byte merged into its column slot
  always_comb begin
    row_word = 24'h000000;
    case (r)
      2'd0:    row_word = shadow[0];
      2'd1:    row_word = shadow[1];
      default: row_word = shadow[2];
    endcase
    case (c)
      2'd0:    row_word[23:16] = mem_rdata;
      2'd1:    row_word[15:8]  = mem_rdata;
      default: row_word[7:0]   = mem_rdata;
    endcase
  end

  assign last_byte     = (r == 2'd2) && (c == 2'd2);
  assign next_row_base = row_base + stride_q;

  // Window fetch FSM; the final byte goes straight into cache so done and the new window appear together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      r        <= 2'd0;
      c        <= 2'd0;
      row_base <= '0;
      stride_q <= '0;
      for (int i = 0; i < 3; i++) begin
        shadow[i] <= 24'h000000;
        cache[i]  <= 24'h000000;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            busy     <= 1'b1;
            mem_addr <= base_addr;
            row_base <= base_addr;
            stride_q <= row_stride;
            r        <= 2'd0;
            c        <= 2'd0;
          end
        end
        FETCH: begin
          if (flush) begin
            // Abort: the partially filled shadow is simply never published
            state   <= IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
          end else if (mem_req && mem_valid) begin
            for (int i = 0; i < 3; i++) begin
              if (r == 2'(i)) shadow[i] <= row_word;
            end
            if (last_byte) begin
              cache[0] <= shadow[0];
              cache[1] <= shadow[1];
              cache[2] <= row_word;
              done     <= 1'b1;
              state    <= IDLE;
              mem_req  <= 1'b0;
              busy     <= 1'b0;
            end else if (c == 2'd2) begin
              // Row addresses accumulate by stride; no multiplier needed
              c        <= 2'd0;
              r        <= r + 2'd1;
              row_base <= next_row_base;
              mem_addr <= next_row_base;
            end else begin
              c        <= c + 2'd1;
              mem_addr <= row_base + ADDR_W'(c + 2'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_window_loader.sv
// tb/tb_kernel_window_loader.sv - randomized self-checking bench for kernel_window_loader
module tb_kernel_window_loader;

  localparam int AW = 18;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          flush;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] row_stride;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          mem_valid;
  logic [23:0]   cache [0:2];
  logic          busy;
  logic          done;

  kernel_window_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .base_addr(base_addr), .row_stride(row_stride),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .cache(cache), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [7:0]    salt     = 8'h00;
  int            wait_w   = 0;
  int            resp_cnt = 0;
  logic [AW-1:0] held_addr;
  bit            addr_unstable;
  logic [AW-1:0] addr_q [$];
  int            done_q [$];
  int            busy_cnt;
  logic          req_after_flush;
  bit            cache_early;
  logic [23:0]   cache_done [0:2];
  logic [23:0]   exp_w [0:2];

  // Memory contents: low address byte scrambled with a per-test salt
  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0] ^ salt;
  endfunction

  // Reference: pixel (r,c) lives at base + r*stride + c, modulo 2^AW
  function automatic logic [AW-1:0] pix_addr(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                                             input int rr, input int cc);
    logic [AW-1:0] a;
    a = base + AW'(rr) * stride + AW'(cc);
    return a;
  endfunction

  task automatic build_expected(input logic [AW-1:0] base, input logic [AW-1:0] stride);
    for (int rr = 0; rr < 3; rr++) begin
      exp_w[rr] = {mem_byte(pix_addr(base, stride, rr, 0)),
                   mem_byte(pix_addr(base, stride, rr, 1)),
                   mem_byte(pix_addr(base, stride, rr, 2))};
    end
  endtask

  // Memory responder: answers each request after wait_w idle cycles, logs served addresses
  initial begin
    mem_valid = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_valid) resp_cnt = 0;
      mem_valid = 1'b0;
      if (!mem_req || !rst_n) begin
        resp_cnt = 0;
      end else begin
        if (resp_cnt == 0) held_addr = mem_addr;
        else if (mem_addr !== held_addr) addr_unstable = 1'b1;
        if (resp_cnt >= wait_w) begin
          mem_valid = 1'b1;
          mem_rdata = mem_byte(mem_addr);
          addr_q.push_back(mem_addr);
        end else begin
          resp_cnt++;
        end
      end
    end
  end

  // Issues one start in cycle 0 and observes ncyc cycles; optional restart and flush injection
  task automatic run_load(input logic [AW-1:0] base, input logic [AW-1:0] stride, input int w,
                          input int restart_cyc, input logic [AW-1:0] restart_base,
                          input bit restart_on_done, input int flush_cyc, input int ncyc);
    logic [23:0] prev [0:2];
    wait_w = w;
    addr_q.delete();
    done_q.delete();
    busy_cnt = 0;
    cache_early = 1'b0;
    addr_unstable = 1'b0;
    req_after_flush = 1'bx;
    @(negedge clk);
    base_addr = base;
    row_stride = stride;
    start = 1'b1;
    for (int i = 0; i < 3; i++) prev[i] = cache[i];
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_q.push_back(cyc);
        for (int i = 0; i < 3; i++) cache_done[i] = cache[i];
      end else begin
        for (int i = 0; i < 3; i++) if (cache[i] !== prev[i]) cache_early = 1'b1;
      end
      for (int i = 0; i < 3; i++) prev[i] = cache[i];
      if (cyc == flush_cyc + 1) req_after_flush = mem_req;
      if (cyc == restart_cyc || (restart_on_done && done && done_q.size() == 1)) begin
        start = 1'b1;
        base_addr = restart_base;
      end
      if (cyc == flush_cyc) flush = 1'b1;
    end
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (cache[i] !== 24'h0) begin n_fail++; $display("FAIL reset_cache%0d got %h want 000000", i, cache[i]); end
    end
  endtask

  task automatic test_zero_wait();
    logic [AW-1:0] ea;
    salt = 8'h00;
    run_load(18'h00100, 18'h00010, 0, -1, '0, 1'b0, -1, 14);
    n_checks++; if (done_q.size() != 1 || done_q[0] != 10) begin n_fail++; $display("FAIL zw_done_cycle got n=%0d c=%0d want n=1 c=10", done_q.size(), done_q[0]); end
    n_checks++; if (busy_cnt != 9) begin n_fail++; $display("FAIL zw_busy_cycles got %0d want 9", busy_cnt); end
    n_checks++; if (addr_q.size() != 9) begin n_fail++; $display("FAIL zw_req_count got %0d want 9", addr_q.size()); end
    for (int k = 0; k < 9 && k < addr_q.size(); k++) begin
      ea = pix_addr(18'h00100, 18'h00010, k / 3, k % 3);
      n_checks++; if (addr_q[k] !== ea) begin n_fail++; $display("FAIL zw_addr%0d got %h want %h", k, addr_q[k], ea); end
    end
    n_checks++; if (cache_done[0] !== 24'h000102) begin n_fail++; $display("FAIL zw_cache0 got %h want 000102", cache_done[0]); end
    n_checks++; if (cache_done[1] !== 24'h101112) begin n_fail++; $display("FAIL zw_cache1 got %h want 101112", cache_done[1]); end
    n_checks++; if (cache_done[2] !== 24'h202122) begin n_fail++; $display("FAIL zw_cache2 got %h want 202122", cache_done[2]); end
    n_checks++; if (cache_early) begin n_fail++; $display("FAIL zw_cache_early got 1 want 0"); end
  endtask

  task automatic test_wait_states();
    salt = 8'h00;
    run_load(18'h00100, 18'h00010, 2, -1, '0, 1'b0, -1, 32);
    n_checks++; if (done_q.size() != 1 || done_q[0] != 28) begin n_fail++; $display("FAIL ws_done_cycle got n=%0d c=%0d want n=1 c=28", done_q.size(), done_q[0]); end
    n_checks++; if (busy_cnt != 27) begin n_fail++; $display("FAIL ws_busy_cycles got %0d want 27", busy_cnt); end
    n_checks++; if (addr_unstable) begin n_fail++; $display("FAIL ws_addr_stable got unstable want stable"); end
    n_checks++; if (cache_done[0] !== 24'h000102 || cache_done[1] !== 24'h101112 || cache_done[2] !== 24'h202122)
      begin n_fail++; $display("FAIL ws_cache got %h %h %h want 000102 101112 202122", cache_done[0], cache_done[1], cache_done[2]); end
  endtask

  task automatic test_addr_wrap();
    salt = 8'($urandom);
    run_load(18'h3FFFF, 18'h3FFF0, 0, -1, '0, 1'b0, -1, 14);
    build_expected(18'h3FFFF, 18'h3FFF0);
    n_checks++; if (addr_q.size() != 9) begin n_fail++; $display("FAIL wrap_req_count got %0d want 9", addr_q.size()); end
    n_checks++; if (addr_q[0] !== 18'h3FFFF || addr_q[1] !== 18'h00000 || addr_q[2] !== 18'h00001)
      begin n_fail++; $display("FAIL wrap_row0 got %h %h %h want 3ffff 00000 00001", addr_q[0], addr_q[1], addr_q[2]); end
    n_checks++; if (addr_q[3] !== 18'h3FFEF) begin n_fail++; $display("FAIL wrap_row1_start got %h want 3ffef", addr_q[3]); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (cache_done[i] !== exp_w[i]) begin n_fail++; $display("FAIL wrap_cache%0d got %h want %h", i, cache_done[i], exp_w[i]); end
    end
  endtask

  task automatic test_start_while_busy();
    salt = 8'h33;
    run_load(18'h01200, 18'h00100, 0, 4, 18'h00040, 1'b0, -1, 20);
    build_expected(18'h01200, 18'h00100);
    n_checks++; if (done_q.size() != 1 || done_q[0] != 10) begin n_fail++; $display("FAIL swb_done got n=%0d c=%0d want n=1 c=10", done_q.size(), done_q[0]); end
    n_checks++; if (addr_q.size() != 9) begin n_fail++; $display("FAIL swb_req_count got %0d want 9", addr_q.size()); end
    for (int k = 0; k < 9 && k < addr_q.size(); k++) begin
      n_checks++; if (addr_q[k] !== pix_addr(18'h01200, 18'h00100, k / 3, k % 3))
        begin n_fail++; $display("FAIL swb_addr%0d got %h want %h", k, addr_q[k], pix_addr(18'h01200, 18'h00100, k / 3, k % 3)); end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (cache_done[i] !== exp_w[i]) begin n_fail++; $display("FAIL swb_cache%0d got %h want %h", i, cache_done[i], exp_w[i]); end
    end
  endtask

  task automatic test_flush();
    logic [23:0] old_w [0:2];
    salt = 8'h5A;
    run_load(18'h02000, 18'h00040, 0, -1, '0, 1'b0, -1, 12);
    build_expected(18'h02000, 18'h00040);
    for (int i = 0; i < 3; i++) old_w[i] = exp_w[i];
    n_checks++; if (cache[0] !== old_w[0] || cache[1] !== old_w[1] || cache[2] !== old_w[2])
      begin n_fail++; $display("FAIL flush_preload got %h %h %h want %h %h %h", cache[0], cache[1], cache[2], old_w[0], old_w[1], old_w[2]); end
    salt = 8'hC3;
    run_load(18'h03000, 18'h00080, 0, -1, '0, 1'b0, 5, 16);
    n_checks++; if (req_after_flush !== 1'b0) begin n_fail++; $display("FAIL flush_req_cycle6 got %b want 0", req_after_flush); end
    n_checks++; if (done_q.size() != 0) begin n_fail++; $display("FAIL flush_no_done got %0d pulses want 0", done_q.size()); end
    n_checks++; if (busy_cnt != 5) begin n_fail++; $display("FAIL flush_busy_cycles got %0d want 5", busy_cnt); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (cache[i] !== old_w[i]) begin n_fail++; $display("FAIL flush_keep_cache%0d got %h want %h", i, cache[i], old_w[i]); end
    end
    run_load(18'h03000, 18'h00080, 1, -1, '0, 1'b0, -1, 24);
    build_expected(18'h03000, 18'h00080);
    n_checks++; if (done_q.size() != 1 || done_q[0] != 19) begin n_fail++; $display("FAIL flush_reload_done got n=%0d c=%0d want n=1 c=19", done_q.size(), done_q[0]); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (cache_done[i] !== exp_w[i]) begin n_fail++; $display("FAIL flush_reload_cache%0d got %h want %h", i, cache_done[i], exp_w[i]); end
    end
  endtask

  task automatic test_reset_mid_load();
    salt = 8'h11;
    wait_w = 0;
    @(negedge clk);
    base_addr = 18'h04000;
    row_stride = 18'h00020;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid_ctrl got req=%b busy=%b done=%b want 0 0 0", mem_req, busy, done); end
    n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_mid_addr got %h want 0", mem_addr); end
    n_checks++; if (cache[0] !== 24'h0 || cache[1] !== 24'h0 || cache[2] !== 24'h0)
      begin n_fail++; $display("FAIL rst_mid_cache got %h %h %h want 0", cache[0], cache[1], cache[2]); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || cache[2] !== 24'h0) begin n_fail++; $display("FAIL rst_mid_idle got busy=%b cache2=%h want 0 0", busy, cache[2]); end
    run_load(18'h04000, 18'h00020, 0, -1, '0, 1'b0, -1, 14);
    build_expected(18'h04000, 18'h00020);
    n_checks++; if (done_q.size() != 1 || done_q[0] != 10) begin n_fail++; $display("FAIL rst_mid_reload_done got n=%0d c=%0d want n=1 c=10", done_q.size(), done_q[0]); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (cache_done[i] !== exp_w[i]) begin n_fail++; $display("FAIL rst_mid_reload_cache%0d got %h want %h", i, cache_done[i], exp_w[i]); end
    end
  endtask

  task automatic test_back_to_back();
    salt = 8'h7E;
    run_load(18'h00100, 18'h00010, 0, -1, 18'h00200, 1'b1, -1, 24);
    build_expected(18'h00200, 18'h00010);
    n_checks++; if (done_q.size() != 2 || done_q[0] != 10 || done_q[1] != 20)
      begin n_fail++; $display("FAIL b2b_done got n=%0d c0=%0d c1=%0d want 2 10 20", done_q.size(), done_q[0], done_q[1]); end
    n_checks++; if (addr_q.size() != 18 || addr_q[9] !== 18'h00200)
      begin n_fail++; $display("FAIL b2b_second_start got n=%0d a=%h want 18 00200", addr_q.size(), addr_q[9]); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (cache_done[i] !== exp_w[i]) begin n_fail++; $display("FAIL b2b_cache%0d got %h want %h", i, cache_done[i], exp_w[i]); end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] b;
    logic [AW-1:0] s;
    int            w;
    int            lat;
    for (int t = 0; t < 6; t++) begin
      b = AW'($urandom);
      s = AW'($urandom);
      w = $urandom_range(0, 3);
      salt = 8'($urandom);
      lat = 1 + 9 * (1 + w);
      run_load(b, s, w, -1, '0, 1'b0, -1, lat + 4);
      build_expected(b, s);
      n_checks++; if (done_q.size() != 1 || done_q[0] != lat)
        begin n_fail++; $display("FAIL rnd%0d_done got n=%0d c=%0d want n=1 c=%0d", t, done_q.size(), done_q[0], lat); end
      n_checks++; if (busy_cnt != lat - 1) begin n_fail++; $display("FAIL rnd%0d_busy got %0d want %0d", t, busy_cnt, lat - 1); end
      n_checks++; if (addr_unstable || cache_early) begin n_fail++; $display("FAIL rnd%0d_stability got addr=%b cache=%b want 0 0", t, addr_unstable, cache_early); end
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (cache_done[i] !== exp_w[i]) begin n_fail++; $display("FAIL rnd%0d_cache%0d got %h want %h", t, i, cache_done[i], exp_w[i]); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    base_addr = '0;
    row_stride = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_addr_wrap();
    test_start_while_busy();
    test_flush();
    test_reset_mid_load();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kernel_window_loader.md
# kernel_window_loader

Loads the 3×3 pixel window consumed by the execute-stage ALU's kernel unit. On `start`, it fetches nine 8-bit pixels from data memory: three rows of three consecutive bytes, with rows separated by a programmable stride. It packs them into the three 24-bit cache words that drive the ALU `cache` input. The block sits directly upstream of the ALU. Its `busy` output stalls the pipeline while a window is in flight, and it publishes a completed window atomically so the kernel never sees a partially updated window.

## Interface
- `ADDR_W`, default 18: byte address width of data memory.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a window load; sampled only in IDLE.
- `flush`  in  1  synchronous abort of an in-flight load.
- `base_addr`  in  ADDR_W  address of the top-left pixel; sampled with `start`.
- `row_stride`  in  ADDR_W  byte distance between rows; sampled with `start`.
- `mem_req`  out  1  read request.
- `mem_addr`  out  ADDR_W  read address; stable while `mem_req` is high.
- `mem_rdata`  in  8  read data; valid when `mem_valid` is high.
- `mem_valid`  in  1  read completion; may assert in the same cycle as `mem_req` or any later cycle.
- `cache[0:2]`  out  24 each  published window; `cache[r]` is row r.
- `busy`  out  1  high in FETCH; used as the pipeline stall.
- `done`  out  1  one-cycle pulse when a new window has been published.

## Operation
- FSM states are IDLE and FETCH.
- **IDLE → FETCH** occurs on `start`=1 and `flush`=0. On that transition the block:
  - latches `base_addr` and `row_stride`;
  - clears the row counter r and column counter c to 0;
  - sets `row_base` = `base_addr`.
- **FETCH:**
  - `mem_req` = 1 and `mem_addr` = `row_base` + c.
  - The block holds both until `mem_valid`=1.
  - On `mem_valid`=1, it writes `mem_rdata` into the shadow buffer at `shadow[r][23-8c -: 8]`. Column 0 occupies bits 23:16 and column 2 occupies bits 7:0.
  - It then advances c. When c wraps 2→0, r increments and `row_base` += `row_stride`.
- **Last byte (r=2, c=2) captured:**
  - On the next edge, `cache` ← `shadow` (all three words together).
  - `done` pulses for one cycle.
  - The FSM returns to IDLE.
- Only one request is outstanding at a time. `mem_valid` is ignored whenever `mem_req` is 0.
- Address arithmetic is modulo 2^ADDR_W; both `row_base` and `row_base` + c wrap silently. Row addresses come from the accumulator, with no multiplier.
- `start` in FETCH is ignored; it is not queued.
- `flush` in FETCH:
  - next state is IDLE;
  - `mem_req` drops;
  - the shadow buffer is discarded and `cache` is unchanged;
  - no `done` is issued.
- `flush` has priority over a `mem_valid` arriving in the same cycle; that byte is dropped.
- `flush` in IDLE has no effect, and it blocks a simultaneous `start`.

## Timing
- Reset values (asynchronous, on `rst_n`=0, in any state):
  - state = IDLE;
  - `mem_req`, `busy`, `done` = 0;
  - `mem_addr` = 0;
  - `cache[0..2]` = 24'h000000;
  - shadow buffer, counters and `row_base` = 0.
- A reset during FETCH abandons the load; the memory side must tolerate a request dropping without completion.
- Cycle numbering:
  - Cycle 0: `start` sampled.
  - Cycle 1: first `mem_req` with `mem_addr` = `base_addr`.
  - Each access takes 1 + W cycles, where W is the number of wait cycles before `mem_valid`.
  - With W=0 the requests occupy cycles 1–9, then `cache` updates and `done`=1 in cycle 10.
  - General latency from `start` to `done` is 1 + 9·(1+W) cycles.
- `busy` equals (state == FETCH). It is low in the `done` cycle.
- A `start` asserted in the `done` cycle is accepted; that cycle becomes cycle 0 of the next load.
- `cache` changes only in the `done` cycle or at reset.

## Test plan
- **Zero-wait load:** memory bytes hold addr[7:0]; base 0x100, stride 0x10, `mem_valid` tied to `mem_req`. Requests must go to 0x100, 0x101, 0x102, 0x110, …, 0x122. In cycle 10, `done` pulses with `cache` = {0x000102, 0x101112, 0x202122}.
- **Wait states:** same load with W=2 on every access. `mem_addr` must stay stable while `mem_valid` is low, `busy` must be high for 27 cycles, and `done` must fire in cycle 28 with the same `cache`.
- **Address wrap:** ADDR_W=18, base 0x3FFFF, stride 0x3FFF0. The first row must read 0x3FFFF, 0x00000, 0x00001 and the second row must start at 0x3FFEF.
- **Start while busy:** pulse `start` with a new base in cycle 4. The load must complete exactly as the original, with one `done` and no second load.
- **Flush mid-load:** preload the window with a known value, start a new load, and assert `flush` in cycle 5 together with `mem_valid`. `mem_req` must be 0 in cycle 6, `cache` must keep the old window, and `done` must stay low. A following `start` must load normally.
- **Reset mid-load:** drop `rst_n` asynchronously between edges in cycle 6. Outputs must go to their reset values immediately. After release, `cache` must be 0 and the FSM must be in IDLE, accepting a new `start`.
